// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage.
//   - ALU command encodings (exe_cmd)
//   - FSM state encoding for ex_mc_stage
//   - bit positions of the {N,Z,C,V} flag nibble
package ex_pkg;

    // ALU command encodings
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Flag nibble layout {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } ex_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: shift-add multiplier, one multiplier bit per cycle.
//   start   : load operands/accumulator and begin iterating
//   clear   : abandon any multiply in progress
//   op_a    : multiplicand, op_b : multiplier, acc : initial accumulator
//   done    : high for one cycle once DATA_W iterations have completed
//   product : low DATA_W bits of op_a*op_b + acc (valid while done)
module ex_mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] acc,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;

    assign done    = run_q && (cnt_q == CNT_W'(DATA_W));
    assign product = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (clear) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= acc;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            if (done) begin
                // product is held in acc_q until the next start
                cnt_q <= '0;
                run_q <= 1'b0;
            end else begin
                // shifted-out multiplicand bits fall off: wraps mod 2^DATA_W
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ex_mc_stage.sv
// ex_mc_stage: execute stage with operand forwarding, single-cycle ALU and
// an iterative multiply/multiply-accumulate path.
//   CLK, RST (async, active-low)
//   in_valid/in_ready   : upstream handshake (accept when both high)
//   exe_cmd, mul_en, mla, imm, imm_val, val_rn, val_rm, val_acc : operation
//   sr_in, s_en         : incoming flags and flag-update request
//   fwd_sel1/2, fwd_data: forwarding selects and packed sources (k at slice k-1)
//   flush               : abort whatever is in flight
//   out_valid/out_ready : downstream handshake
//   alu_result, val_rm_out, sr_out, sr_we, busy : results
module ex_mc_stage
    import ex_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int FWD_N  = 2,
    localparam int FS_W   = $clog2(FWD_N + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              exe_cmd,
    input  logic                    mul_en,
    input  logic                    mla,
    input  logic [3:0]              sr_in,
    input  logic                    s_en,
    input  logic [DATA_W-1:0]       val_rn,
    input  logic [DATA_W-1:0]       val_rm,
    input  logic [DATA_W-1:0]       val_acc,
    input  logic [DATA_W-1:0]       imm_val,
    input  logic                    imm,
    input  logic [FS_W-1:0]         fwd_sel1,
    input  logic [FS_W-1:0]         fwd_sel2,
    input  logic [FWD_N*DATA_W-1:0] fwd_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       alu_result,
    output logic [DATA_W-1:0]       val_rm_out,
    output logic [3:0]              sr_out,
    output logic                    sr_we,
    output logic                    busy
);

    localparam int MSB = DATA_W - 1;

    ex_state_e         state_q, state_d;
    logic              accept;
    logic [DATA_W-1:0] op1, rm_fwd, op2;
    logic [DATA_W-1:0] alu_res, product;
    logic [3:0]        alu_flags, mul_flags;
    logic [DATA_W:0]   add_sum, sub_sum;
    logic              cin_add, cin_sub, mul_done;
    logic              sr_we_q, cap_c_q, cap_v_q;

    // Forwarding: out-of-range selects fall back to the register value
    always_comb begin
        op1    = val_rn;
        rm_fwd = val_rm;
        for (int k = 1; k <= FWD_N; k++) begin
            if (fwd_sel1 == FS_W'(k)) op1    = fwd_data[(k-1)*DATA_W +: DATA_W];
            if (fwd_sel2 == FS_W'(k)) rm_fwd = fwd_data[(k-1)*DATA_W +: DATA_W];
        end
    end
    assign op2 = imm ? imm_val : rm_fwd;

    // Subtract as op1 + ~op2 + cin so carry-out is NOT borrow
    assign cin_add = (exe_cmd == CMD_ADC) ? sr_in[FLAG_C] : 1'b0;
    assign cin_sub = (exe_cmd == CMD_SBC) ? sr_in[FLAG_C] : 1'b1;
    assign add_sum = {1'b0, op1} + {1'b0, op2}  + {{DATA_W{1'b0}}, cin_add};
    assign sub_sum = {1'b0, op1} + {1'b0, ~op2} + {{DATA_W{1'b0}}, cin_sub};

    always_comb begin
        alu_res   = '0;
        alu_flags = sr_in;
        case (exe_cmd)
            CMD_ADD, CMD_ADC: begin
                alu_res           = add_sum[MSB:0];
                alu_flags[FLAG_C] = add_sum[DATA_W];
                alu_flags[FLAG_V] = (op1[MSB] == op2[MSB]) && (alu_res[MSB] != op1[MSB]);
            end
            CMD_SUB, CMD_SBC: begin
                alu_res           = sub_sum[MSB:0];
                alu_flags[FLAG_C] = sub_sum[DATA_W];
                alu_flags[FLAG_V] = (op1[MSB] != op2[MSB]) && (alu_res[MSB] != op1[MSB]);
            end
            CMD_MOV: alu_res = op2;
            CMD_MVN: alu_res = ~op2;
            CMD_AND: alu_res = op1 & op2;
            CMD_ORR: alu_res = op1 | op2;
            CMD_EOR: alu_res = op1 ^ op2;
            default: alu_res = '0;
        endcase
        // N/Z only move for recognised commands; unknown codes keep sr_in
        case (exe_cmd)
            CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
            CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR: begin
                alu_flags[FLAG_N] = alu_res[MSB];
                alu_flags[FLAG_Z] = (alu_res == '0);
            end
            default: ;
        endcase
    end

    ex_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk     (CLK),
        .rst_n   (RST),
        .start   (accept && mul_en),
        .clear   (flush),
        .op_a    (op1),
        .op_b    (op2),
        .acc     (mla ? val_acc : '0),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_N] = product[MSB];
        mul_flags[FLAG_Z] = (product == '0);
        mul_flags[FLAG_C] = cap_c_q;
        mul_flags[FLAG_V] = cap_v_q;
    end

    // FSM
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        in_ready = ((state_q == ST_IDLE) || (state_q == ST_HOLD && out_ready)) && !flush;
        accept   = in_valid && in_ready;
        state_d  = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = mul_en ? ST_MUL : ST_HOLD;
            ST_MUL:  if (mul_done) state_d = ST_HOLD;
            ST_HOLD: begin
                if (accept)         state_d = mul_en ? ST_MUL : ST_HOLD;
                else if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_MUL);
    assign sr_we     = sr_we_q && out_valid;

    // Result registers only change on accept or multiply completion, so they
    // hold steady while a result waits for out_ready.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_result <= '0;
            val_rm_out <= '0;
            sr_out     <= '0;
            sr_we_q    <= 1'b0;
            cap_c_q    <= 1'b0;
            cap_v_q    <= 1'b0;
        end else if (accept) begin
            val_rm_out <= rm_fwd;
            sr_we_q    <= s_en;
            if (mul_en) begin
                cap_c_q <= sr_in[FLAG_C];
                cap_v_q <= sr_in[FLAG_V];
            end else begin
                alu_result <= alu_res;
                sr_out     <= alu_flags;
            end
        end else if (state_q == ST_MUL && mul_done && !flush) begin
            alu_result <= product;
            sr_out     <= mul_flags;
        end
    end

endmodule

// File: tb/tb_ex_mc_stage.sv
// tb_ex_mc_stage: directed table-driven checks of ex_mc_stage plus
// hand-written sequences for multiply, back-pressure, flush and reset.
module tb_ex_mc_stage;
    import ex_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [3:0]  exe_cmd = '0;
    logic        mul_en = 1'b0, mla = 1'b0;
    logic [3:0]  sr_in = '0;
    logic        s_en = 1'b0;
    logic [31:0] val_rn = '0, val_rm = '0, val_acc = '0, imm_val = '0;
    logic        imm = 1'b0;
    logic [1:0]  fwd_sel1 = '0, fwd_sel2 = '0;
    logic [63:0] fwd_data = {32'h0000_0010, 32'hAAAA_0000};
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] alu_result, val_rm_out;
    logic [3:0]  sr_out;
    logic        sr_we, busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    ex_mc_stage dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .mul_en(mul_en), .mla(mla),
        .sr_in(sr_in), .s_en(s_en),
        .val_rn(val_rn), .val_rm(val_rm), .val_acc(val_acc), .imm_val(imm_val),
        .imm(imm), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .val_rm_out(val_rm_out),
        .sr_out(sr_out), .sr_we(sr_we), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] rn, rm, immv;
        logic        imm;
        logic [1:0]  s1, s2;
        logic [3:0]  sr;
        logic        sen;
        logic [31:0] res;
        logic [3:0]  sro;
        logic [31:0] rmo;
    } vec_t;

    vec_t v[14];

    task automatic drive_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm);
        in_valid = 1'b1; mul_en = 1'b0; mla = 1'b0; exe_cmd = cmd;
        val_rn = rn; val_rm = rm; imm = 1'b0; fwd_sel1 = 0; fwd_sel2 = 0;
        sr_in = 4'b0000; s_en = 1'b0;
    endtask

    task automatic start_mul(input logic [31:0] rn, input logic [31:0] rm,
                             input logic [31:0] acc, input logic do_mla, input logic [3:0] sr);
        in_valid = 1'b1; mul_en = 1'b1; mla = do_mla; exe_cmd = 4'h0;
        val_rn = rn; val_rm = rm; val_acc = acc; imm = 1'b0;
        fwd_sel1 = 0; fwd_sel2 = 0; sr_in = sr; s_en = 1'b1;
        @(negedge CLK);          // accepted on the edge just passed
        in_valid = 1'b0; mul_en = 1'b0; mla = 1'b0;
    endtask

    initial begin
        int k;
        logic seen;
        //        cmd      rn            rm            immv          imm s1 s2 sr       sen  res           sro      rmo
        v[0]  = '{CMD_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h0,        0,  0, 0, 4'b0000, 1, 32'h80000000, 4'b1001, 32'h00000001};
        v[1]  = '{CMD_SBC, 32'h5,        32'h5,        32'h0,        0,  0, 0, 4'b0000, 1, 32'hFFFFFFFF, 4'b1000, 32'h5};
        v[2]  = '{CMD_SBC, 32'h5,        32'h5,        32'h0,        0,  0, 0, 4'b0010, 1, 32'h00000000, 4'b0110, 32'h5};
        v[3]  = '{CMD_ADD, 32'h999,      32'h0,        32'h3,        1,  2, 0, 4'b0000, 0, 32'h00000013, 4'b0000, 32'h0};
        v[4]  = '{CMD_ADD, 32'h20,       32'h0,        32'h3,        1,  3, 0, 4'b0000, 0, 32'h00000023, 4'b0000, 32'h0};
        v[5]  = '{CMD_ADC, 32'hFFFFFFFF, 32'h0,        32'h0,        0,  0, 0, 4'b0010, 1, 32'h00000000, 4'b0110, 32'h0};
        v[6]  = '{CMD_SUB, 32'h3,        32'h5,        32'h0,        0,  0, 0, 4'b0000, 1, 32'hFFFFFFFE, 4'b1000, 32'h5};
        v[7]  = '{CMD_AND, 32'hF0F0,     32'hFF00,     32'h0,        0,  0, 0, 4'b0011, 1, 32'h0000F000, 4'b0011, 32'hFF00};
        v[8]  = '{CMD_ORR, 32'h80000000, 32'h1,        32'h0,        0,  0, 0, 4'b0000, 1, 32'h80000001, 4'b1000, 32'h1};
        v[9]  = '{CMD_EOR, 32'h1234,     32'h1234,     32'h0,        0,  0, 0, 4'b0001, 1, 32'h00000000, 4'b0101, 32'h1234};
        v[10] = '{CMD_MOV, 32'h77,       32'h5,        32'h0,        1,  0, 0, 4'b0010, 1, 32'h00000000, 4'b0110, 32'h5};
        v[11] = '{CMD_MVN, 32'h0,        32'h0,        32'h0,        0,  0, 1, 4'b0000, 1, 32'h5555FFFF, 4'b0000, 32'hAAAA0000};
        v[12] = '{4'hF,    32'h1,        32'h2,        32'h0,        0,  0, 0, 4'b1011, 1, 32'h00000000, 4'b1011, 32'h2};
        v[13] = '{CMD_SUB, 32'h80000000, 32'h1,        32'h0,        0,  0, 0, 4'b0000, 1, 32'h7FFFFFFF, 4'b0011, 32'h1};

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sr_we", 32'(sr_we), 32'd0);
        chk("rst_result", alu_result, 32'd0);
        chk("rst_sr_out", 32'(sr_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Release reset at a negedge; first vector accepted on the next edge
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1; mul_en = 1'b0; exe_cmd = v[i].cmd;
            val_rn = v[i].rn; val_rm = v[i].rm; imm_val = v[i].immv; imm = v[i].imm;
            fwd_sel1 = v[i].s1; fwd_sel2 = v[i].s2; sr_in = v[i].sr; s_en = v[i].sen;
            #1 chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            @(negedge CLK);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_result", i), alu_result, v[i].res);
            chk($sformatf("v%0d_sr_out", i), 32'(sr_out), 32'(v[i].sro));
            chk($sformatf("v%0d_sr_we", i), 32'(sr_we), 32'(v[i].sen));
            chk($sformatf("v%0d_rm_out", i), val_rm_out, v[i].rmo);
        end
        in_valid = 1'b0;
        @(negedge CLK);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // MLA 7*6+100 with latency DATA_W+1, then back-pressure
        out_ready = 1'b0;
        start_mul(32'd7, 32'd6, 32'd100, 1'b1, 4'b0011);
        k = 0;
        chk("mul_busy", 32'(busy), 32'd1);
        chk("mul_in_ready", 32'(in_ready), 32'd0);
        while (!out_valid && k < 60) begin
            @(negedge CLK);
            k++;
        end
        chk("mla_latency", 32'(k), 32'd33);
        chk("mla_result", alu_result, 32'd142);
        chk("mla_sr_out", 32'(sr_out), 32'(4'b0011));
        chk("mla_sr_we", 32'(sr_we), 32'd1);
        chk("mla_busy_off", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; exe_cmd = CMD_ADD; val_rn = 32'h55; val_rm = 32'h1;
            #1 chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge CLK);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", alu_result, 32'd142);
            chk("hold_sr_out", 32'(sr_out), 32'(4'b0011));
        end

        // Stream 4 ADDs with out_ready high: one result per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_alu(CMD_ADD, 32'(i), 32'd10);
            @(negedge CLK);
            chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d_result", i), alu_result, 32'(10 + i));
        end
        in_valid = 1'b0;
        @(negedge CLK);

        // flush at iteration 10 of a multiply, with in_valid held high
        start_mul(32'd3, 32'd4, 32'd0, 1'b0, 4'b0000);
        for (int i = 1; i < 10; i++) @(negedge CLK);
        flush = 1'b1; in_valid = 1'b1; exe_cmd = CMD_ADD; mul_en = 1'b0;
        #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(negedge CLK);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", 32'(seen), 32'd0);

        // flush beats out_ready in HOLD
        drive_alu(CMD_ADD, 32'd1, 32'd2);
        @(negedge CLK);
        chk("fh_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0; in_valid = 1'b0;
        chk("fh_valid_drop", 32'(out_valid), 32'd0);

        // async reset at iteration 10 of a multiply
        start_mul(32'd9, 32'd9, 32'd0, 1'b0, 4'b0000);
        for (int i = 1; i < 10; i++) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_result", alu_result, 32'd0);
        chk("arst_rm_out", val_rm_out, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (out_valid) seen = 1'b1;
        end
        chk("arst_no_result", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
